// File: rtl/i2c_regfile.sv
// -----------------------------------------------------------------------------
// i2c_regfile
//   Byte-wide register file that sits behind an I2C slave front end. The slave
//   reports transaction framing through one-cycle strobes; this block turns
//   them into a register pointer plus reads and writes. The first byte written
//   after an address strobe loads the pointer. Each later byte is written at
//   the pointer, and the pointer then advances. Each read strobe also advances
//   the pointer. Local logic can also write any register directly.
//
// Parameters
//   NREGS   number of 8-bit registers (power of two, 2..256)
//   AW      pointer width, log2(NREGS)
//   RO_MASK bit k set -> register k cannot be written from I2C
//   INIT    reset contents, register k at [8k+7:8k]
//
// Ports
//   clk        system clock (shared with the I2C slave)
//   rst_n      asynchronous active-low reset
//   act_in     transaction-active level from the slave
//   as_in      one-cycle address strobe
//   ws_in      one-cycle write strobe, wdat_in valid with it
//   rs_in      one-cycle read strobe, slave samples rdat_out on that edge
//   wdat_in    received byte
//   rdat_out   byte to transmit, always register[ptr]
//   hw_we      local write enable
//   hw_addr    local write address
//   hw_dat     local write data
//   regs_out   all register contents, register k at [8k+7:8k]
//   wr_pulse   one-cycle flag per register written from I2C
//   ptr_out    current register pointer
//   state_dbg  FSM state (0 IDLE, 1 PTR, 2 DATA) for observation
//
// Handshake: the strobes carry no backpressure. A strobe is consumed on the
// single rising clk edge where it is high. When as_in is high on that edge,
// it overrides any write or read strobe on the same edge.
// -----------------------------------------------------------------------------
module i2c_regfile #(
   parameter int                     NREGS   = 16,
   parameter int                     AW      = 4,
   parameter logic [NREGS-1:0]       RO_MASK = '0,
   parameter logic [8*NREGS-1:0]     INIT    = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 act_in,
   input  logic                 as_in,
   input  logic                 ws_in,
   input  logic                 rs_in,
   input  logic [7:0]           wdat_in,
   output logic [7:0]           rdat_out,
   input  logic                 hw_we,
   input  logic [AW-1:0]        hw_addr,
   input  logic [7:0]           hw_dat,
   output logic [8*NREGS-1:0]   regs_out,
   output logic [NREGS-1:0]     wr_pulse,
   output logic [AW-1:0]        ptr_out,
   output logic [1:0]           state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PTR  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   state_t        state;
   logic [AW-1:0] ptr;
   logic [7:0]    regs [NREGS];

   // Write and read strobes count only in a live transaction. An address
   // strobe on the same edge takes priority over them.
   logic strobe_ok;
   logic i2c_wr;

   always_comb begin
      strobe_ok = act_in && !as_in;
      i2c_wr    = strobe_ok && ws_in && (state == ST_DATA) && !RO_MASK[ptr];
   end

   // Pointer / framing FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         ptr   <= '0;
      end else if (as_in) begin
         state <= ST_PTR;
      end else if (!act_in) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_PTR: begin
               if (ws_in) begin
                  // Upper bits of the pointer byte are discarded.
                  ptr   <= wdat_in[AW-1:0];
                  state <= ST_DATA;
               end else if (rs_in) begin
                  ptr <= ptr + PTR_ONE;
               end
            end
            ST_DATA: begin
               // The pointer advances on read-only registers too. The write
               // itself is suppressed in the register block below.
               if (ws_in || rs_in) begin
                  ptr <= ptr + PTR_ONE;
               end
            end
            default: begin
               // Strobes in IDLE are ignored. The pointer is kept across
               // transactions.
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Register storage. When both write ports hit the same register on the
   // same edge, the I2C write wins. Writes to different registers both land.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NREGS; k++) begin
            regs[k] <= INIT[8*k +: 8];
         end
      end else begin
         for (int k = 0; k < NREGS; k++) begin
            if (i2c_wr && (ptr == AW'(k))) begin
               regs[k] <= wdat_in;
            end else if (hw_we && (hw_addr == AW'(k))) begin
               regs[k] <= hw_dat;
            end
         end
      end
   end

   // One-cycle notification of accepted I2C writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_pulse <= '0;
      end else begin
         for (int k = 0; k < NREGS; k++) begin
            wr_pulse[k] <= i2c_wr && (ptr == AW'(k));
         end
      end
   end

   always_comb begin
      regs_out = '0;
      for (int k = 0; k < NREGS; k++) begin
         regs_out[8*k +: 8] = regs[k];
      end
   end

   assign rdat_out  = regs[ptr];
   assign ptr_out   = ptr;
   assign state_dbg = state;

endmodule
